// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse round engine.
//   WIDTH / DIM     : byte width and state matrix dimension defaults
//   matrix_t        : DIM x DIM byte matrix, indexed [row][col]
//   state_e         : round FSM state encoding
//   INV_SBOX        : inverse S-box table
//   xtime / gf_mul  : GF(2^8) arithmetic, polynomial 0x11B
//   vec2mat/mat2vec : flat vector <-> matrix, byte k = r + DIM*c
package aes_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIM   = 4;
  localparam int unsigned NBITS = DIM * DIM * WIDTH;

  typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] matrix_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INV_SHIFT = 3'd1,
    INV_SUB   = 3'd2,
    ADD_KEY   = 3'd3,
    INV_MIX   = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic matrix_t vec2mat(input logic [NBITS-1:0] v);
    matrix_t m;
    for (int unsigned r = 0; r < DIM; r++)
      for (int unsigned c = 0; c < DIM; c++)
        m[r][c] = v[WIDTH*(r + DIM*c) +: WIDTH];
    return m;
  endfunction

  function automatic logic [NBITS-1:0] mat2vec(input matrix_t m);
    logic [NBITS-1:0] v;
    for (int unsigned r = 0; r < DIM; r++)
      for (int unsigned c = 0; c < DIM; c++)
        v[WIDTH*(r + DIM*c) +: WIDTH] = m[r][c];
    return v;
  endfunction

endpackage

// File: rtl/inv_round_fsm_if.sv
// Handshake bundle for inv_round_fsm.
//   slave  : engine side (state/key in under valid_i/ready_o,
//            result out under valid_o/ready_i)
//   master : feeding/consuming side
interface inv_round_fsm_if
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = aes_pkg::WIDTH,
  parameter int unsigned DIM   = aes_pkg::DIM
);
  logic                       valid_i;
  logic                       ready_o;
  logic                       last_i;
  logic [DIM*DIM*WIDTH-1:0]   state_i;
  logic [DIM*DIM*WIDTH-1:0]   key_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [DIM*DIM*WIDTH-1:0]   state_o;

  modport slave (
    input  valid_i, last_i, state_i, key_i, ready_i,
    output ready_o, valid_o, state_o
  );

  modport master (
    output valid_i, last_i, state_i, key_i, ready_i,
    input  ready_o, valid_o, state_o
  );
endinterface

// File: rtl/inv_mix_columns.sv
// InvMixColumns over a full state matrix (combinational).
//   mat_i : input matrix [row][col]
//   mat_o : each column multiplied by circulant {0e,0b,0d,09}
module inv_mix_columns
  import aes_pkg::*;
(
  input  matrix_t mat_i,
  output matrix_t mat_o
);
  always_comb begin
    mat_o = '0;
    for (int unsigned c = 0; c < DIM; c++)
      for (int unsigned r = 0; r < DIM; r++)
        mat_o[r][c] = gf_mul(8'h0e, mat_i[r][c])
                    ^ gf_mul(8'h0b, mat_i[(r + 1) % DIM][c])
                    ^ gf_mul(8'h0d, mat_i[(r + 2) % DIM][c])
                    ^ gf_mul(8'h09, mat_i[(r + 3) % DIM][c]);
  end
endmodule

// File: rtl/inv_round_fsm.sv
// AES inverse-cipher round engine: InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns (skipped on the final round), one stage per clock.
//   clk_i  : clock, posedge
//   rst_i  : synchronous active-low reset
//   bus    : inv_round_fsm_if.slave (state/key/last in, result out)
//   With INV_ROUND_TAP_EN defined:
//     tap_stage_o : current FSM state encoding
//     tap_data_o  : work register
module inv_round_fsm
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = aes_pkg::WIDTH,
  parameter int unsigned DIM   = aes_pkg::DIM
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  inv_round_fsm_if.slave           bus
`ifdef INV_ROUND_TAP_EN
  ,
  output logic [2:0]               tap_stage_o,
  output logic [DIM*DIM*WIDTH-1:0] tap_data_o
`endif
);
  localparam int unsigned NB = DIM * DIM * WIDTH;

  state_e          state_q, state_d;
  logic [NB-1:0]   work_q, work_d;
  logic [NB-1:0]   key_q, key_d;
  logic            last_q, last_d;
  // Holds ready_o low during the reset cycle so it stays register-decoded.
  logic            rst_done_q;
  logic            idle_rdy;
  logic            accept;

  matrix_t cur, shifted, subbed, mixed;

  assign idle_rdy = (state_q == IDLE) && rst_done_q;
  assign accept   = bus.valid_i && idle_rdy;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      work_q     <= '0;
      key_q      <= '0;
      last_q     <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      key_q      <= key_d;
      last_q     <= last_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:      state_d = accept ? INV_SHIFT : IDLE;
      INV_SHIFT: state_d = INV_SUB;
      INV_SUB:   state_d = ADD_KEY;
      ADD_KEY:   state_d = last_q ? DONE : INV_MIX;
      INV_MIX:   state_d = DONE;
      DONE:      state_d = bus.ready_i ? IDLE : DONE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = idle_rdy;
    bus.valid_o = (state_q == DONE);
    bus.state_o = work_q;
  end

  always_comb begin
    cur     = vec2mat(work_q);
    shifted = '0;
    subbed  = '0;
    for (int unsigned r = 0; r < DIM; r++)
      for (int unsigned c = 0; c < DIM; c++) begin
        // Right rotation by r: destination column c takes source column c-r.
        shifted[r][c] = cur[r][(c + DIM - r) % DIM];
        subbed[r][c]  = INV_SBOX[cur[r][c]];
      end
  end

  inv_mix_columns u_inv_mix (
    .mat_i (cur),
    .mat_o (mixed)
  );

  always_comb begin
    work_d = work_q;
    key_d  = key_q;
    last_d = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d = bus.state_i;
          key_d  = bus.key_i;
          last_d = bus.last_i;
        end
      end
      INV_SHIFT: work_d = mat2vec(shifted);
      INV_SUB:   work_d = mat2vec(subbed);
      ADD_KEY:   work_d = work_q ^ key_q;
      INV_MIX:   work_d = mat2vec(mixed);
      default:   work_d = work_q;
    endcase
  end

`ifdef INV_ROUND_TAP_EN
  assign tap_stage_o = state_q;
  assign tap_data_o  = work_q;
`endif
endmodule

// File: tb/tb_inv_round_fsm.sv
// Directed self-checking bench for inv_round_fsm: final round, InvMixColumns
// round, backpressure, back-to-back rounds and mid-round reset.
module tb_inv_round_fsm;
  logic clk;
  logic rst_i;
  int   n_checks;
  int   n_fails;

  inv_round_fsm_if bus ();

`ifdef INV_ROUND_TAP_EN
  logic [2:0]   tap_stage;
  logic [127:0] tap_data;
  logic [127:0] tap_exp1, tap_exp2;
  bit           chk_tap;
`endif

  inv_round_fsm dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef INV_ROUND_TAP_EN
    ,
    .tap_stage_o (tap_stage),
    .tap_data_o  (tap_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIPS-197 strings put their leftmost byte at bits [7:0].
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = h[8*(15-i) +: 8];
    return v;
  endfunction

  localparam logic [127:0] FR_IN   = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] FR_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FR_OUT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] MX_IN   = {16{8'h63}};
  localparam logic [127:0] MX_KEY  = {4{32'h8e4da1bc}};
  localparam logic [127:0] MX_OUT  = {4{32'hdb135345}};
  // All-equal column: InvMixColumns is identity; InvSbox(52) = 48.
  localparam logic [127:0] EQ_IN   = {16{8'h52}};
  localparam logic [127:0] EQ_OUT  = {16{8'h48}};

  // Leaves the engine in DONE (ready_i low) after checking latency and result.
  task automatic run_round(input string tag, input logic [127:0] s, input logic [127:0] k,
                           input logic last, input logic [127:0] exp, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    bus.state_i = s;
    bus.key_i   = k;
    bus.last_i  = last;
    bus.valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept"}, 128'(seen), 128'd1);
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
`ifdef INV_ROUND_TAP_EN
      if (chk_tap && lat == 1) check({tag, "_tap1"}, tap_data, tap_exp1);
      if (chk_tap && lat == 2) check({tag, "_tap2"}, tap_data, tap_exp2);
`endif
      if (bus.valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_state_o"}, bus.state_o, exp);
  endtask

  task automatic finish_handshake(input string tag);
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    check({tag, "_ready_after"}, 128'(bus.ready_o), 128'd1);
    check({tag, "_valid_after"}, 128'(bus.valid_o), 128'd0);
  endtask

  initial begin
    int cyc, nacc, nres;
    int acc_cyc [2];
    bit switched;
    logic [127:0] exp_res [2];

    n_checks    = 0;
    n_fails     = 0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.state_i = '0;
    bus.key_i   = '0;
`ifdef INV_ROUND_TAP_EN
    chk_tap = 1'b0;
`endif

    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 128'(bus.ready_o), 128'd0);
    check("rst_valid", 128'(bus.valid_o), 128'd0);
    check("rst_state", bus.state_o, 128'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 128'(bus.ready_o), 128'd1);

    // Final round
`ifdef INV_ROUND_TAP_EN
    chk_tap  = 1'b1;
    tap_exp1 = fips(128'h63cab7040953d051cd60e0e7ba70e18c);
    tap_exp2 = fips(128'h00102030405060708090a0b0c0d0e0f0);
`endif
    run_round("final", fips(FR_IN), fips(FR_KEY), 1'b1, fips(FR_OUT), 3);
`ifdef INV_ROUND_TAP_EN
    chk_tap = 1'b0;
    check("final_tap_stage", 128'(tap_stage), 128'd5);
`endif
    finish_handshake("final");

    // InvMixColumns round, then backpressure while in DONE
    run_round("mix", fips(MX_IN), fips(MX_KEY), 1'b0, fips(MX_OUT), 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.valid_i = i[0];
      bus.state_i = {4{32'hdeadbeef}};
      bus.last_i  = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid", 128'(bus.valid_o), 128'd1);
      check("bp_state", bus.state_o, fips(MX_OUT));
      check("bp_ready", 128'(bus.ready_o), 128'd0);
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    finish_handshake("bp");

    // Back-to-back with ready_i tied high and valid_i held
    @(negedge clk);
    bus.ready_i  = 1'b1;
    bus.valid_i  = 1'b1;
    bus.state_i  = fips(MX_IN);
    bus.key_i    = fips(MX_KEY);
    bus.last_i   = 1'b0;
    exp_res[0]   = fips(MX_OUT);
    exp_res[1]   = EQ_OUT;
    acc_cyc[0]   = 0;
    acc_cyc[1]   = 0;
    cyc = 0; nacc = 0; nres = 0; switched = 1'b0;
    for (int i = 0; i < 40 && nres < 2; i++) begin
      if (bus.valid_o) begin
        check("b2b_result", bus.state_o, exp_res[nres]);
        nres++;
      end
      if (bus.ready_o && bus.valid_i) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end else if (nacc == 1 && !switched) begin
        bus.state_i = EQ_IN;
        bus.key_i   = '0;
        switched    = 1'b1;
      end else if (nacc == 2) begin
        bus.valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_nres", 128'(nres), 128'd2);
    check("b2b_nacc", 128'(nacc), 128'd2);
    check("b2b_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during INV_SUB
    @(negedge clk);
    bus.state_i = fips(FR_IN);
    bus.key_i   = fips(FR_KEY);
    bus.last_i  = 1'b1;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 128'(bus.ready_o), 128'd0);
    check("mid_rst_valid", 128'(bus.valid_o), 128'd0);
    check("mid_rst_state", bus.state_o, 128'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_ready", 128'(bus.ready_o), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("mid_no_valid", 128'(bus.valid_o), 128'd0);
    end
    run_round("fresh", fips(FR_IN), fips(FR_KEY), 1'b1, fips(FR_OUT), 3);
    finish_handshake("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
